mem_access_master: RTL and testbench

Initiator-side load/store engine that sits between the CPU pipeline's memory stage and the data memory (DM). It accepts one load/store request at a time over a valid/ready handshake and checks alignment and address range. It then drives the DM strobe/type port for the access and returns the loaded data or an address-error code to the pipeline. It is the master counterpart of DM's MemWrite/MemRead/StoreType/LoadType/SignRead/Addr/WD/RD port.

---
 rtl/mem_access_master.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_master.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_master.sv
// mem_access_master: load/store initiator between the memory stage and the data memory.
// Define MEM_SPLIT_MISALIGN_EN to replay in-range misaligned half/word accesses as byte beats.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ISSUE | check latched request, strobe DM once or report an address error
// SPLIT | byte beats of a misaligned access (MEM_SPLIT_MISALIGN_EN only)
module mem_access_master #(
    parameter logic [31:0] DM_BASE = 32'h0000_0000,
    parameter logic [31:0] DM_SIZE = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_exc,
    output logic [31:0] resp_badvaddr,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [1:0]  StoreType,
    output logic [1:0]  LoadType,
    output logic        SignRead,
    output logic [31:0] WPC,
    output logic [31:0] Addr,
    output logic [31:0] WD,
    input  logic [31:0] RD
);

`ifdef MEM_SPLIT_MISALIGN_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, SPLIT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1} state_t;
`endif

    state_t      state, nextState;
    logic [2:0]  opQ;
    logic [31:0] addrQ, wdataQ, pcQ;
    logic        isLoad, signExt, misaligned, outOfRange, addrErr, needSplit;
    logic [1:0]  accType;
    logic [32:0] sizeM1, offset, offEnd;

    assign isLoad  = (opQ <= 3'd4);
    assign signExt = (opQ == 3'd0) || (opQ == 3'd1) || (opQ == 3'd3);

    always_comb begin
        case (opQ)
            3'd0, 3'd5:       accType = 2'd0;
            3'd1, 3'd2, 3'd6: accType = 2'd1;
            default:          accType = 2'd2;
        endcase
    end

    // 33-bit offset: bit 32 flags an address below the window, and a span that
    // wraps past the top of the address space can never compare as inside.
    assign sizeM1     = (accType == 2'd0) ? 33'd3 : (accType == 2'd1) ? 33'd1 : 33'd0;
    assign offset     = {1'b0, addrQ} - {1'b0, DM_BASE};
    assign offEnd     = offset + sizeM1;
    assign outOfRange = offset[32] || (offEnd >= {1'b0, DM_SIZE});
    assign misaligned = ((accType == 2'd1) && addrQ[0]) ||
                        ((accType == 2'd0) && (addrQ[1:0] != 2'b00));

`ifdef MEM_SPLIT_MISALIGN_EN
    assign addrErr   = outOfRange;
    assign needSplit = misaligned && !outOfRange;
`else
    assign addrErr   = outOfRange || misaligned;
    assign needSplit = 1'b0;
`endif

    assign req_ready = (state == IDLE);

`ifdef MEM_SPLIT_MISALIGN_EN
    logic [1:0]  beatQ;
    logic [31:0] asmQ, asmNext, splitData;
    logic        lastBeat;

    assign lastBeat = (beatQ == ((accType == 2'd1) ? 2'd1 : 2'd3));

    always_comb begin
        asmNext = asmQ;
        asmNext[{beatQ, 3'b000} +: 8] = RD[7:0];
        case (opQ)
            3'd0:    splitData = asmNext;
            3'd1:    splitData = {{16{asmNext[15]}}, asmNext[15:0]};
            3'd2:    splitData = {16'h0000, asmNext[15:0]};
            default: splitData = 32'h0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req_valid) nextState = ISSUE;
            ISSUE:   nextState = needSplit ? state_t'(2'd2) : IDLE;
`ifdef MEM_SPLIT_MISALIGN_EN
            SPLIT:   if (lastBeat) nextState = IDLE;
`endif
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        StoreType = 2'd0;
        LoadType  = 2'd0;
        SignRead  = 1'b0;
        WPC       = 32'h0;
        Addr      = 32'h0;
        WD        = 32'h0;
        if (state == ISSUE && !addrErr && !needSplit) begin
            MemRead   = isLoad;
            MemWrite  = !isLoad;
            StoreType = accType;
            LoadType  = accType;
            SignRead  = signExt;
            WPC       = pcQ;
            Addr      = addrQ;
            WD        = wdataQ;
        end
`ifdef MEM_SPLIT_MISALIGN_EN
        if (state == SPLIT) begin
            MemRead   = isLoad;
            MemWrite  = !isLoad;
            StoreType = 2'd2;
            LoadType  = 2'd2;
            WPC       = pcQ;
            Addr      = addrQ + {30'd0, beatQ};
            WD        = {24'd0, wdataQ[{beatQ, 3'b000} +: 8]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ           <= 3'd0;
            addrQ         <= 32'h0;
            wdataQ        <= 32'h0;
            pcQ           <= 32'h0;
            resp_valid    <= 1'b0;
            resp_data     <= 32'h0;
            resp_exc      <= 2'b00;
            resp_badvaddr <= 32'h0;
`ifdef MEM_SPLIT_MISALIGN_EN
            beatQ         <= 2'd0;
            asmQ          <= 32'h0;
`endif
        end else begin
            resp_valid <= 1'b0;
            if (state == IDLE && req_valid) begin
                opQ    <= req_op;
                addrQ  <= req_addr;
                wdataQ <= req_wdata;
                pcQ    <= req_pc;
            end
            if (state == ISSUE && !needSplit) begin
                resp_valid    <= 1'b1;
                resp_exc      <= addrErr ? (isLoad ? 2'b01 : 2'b10) : 2'b00;
                resp_badvaddr <= addrErr ? addrQ : 32'h0;
                resp_data     <= (addrErr || !isLoad) ? 32'h0 : RD;
            end
`ifdef MEM_SPLIT_MISALIGN_EN
            if (state == ISSUE) begin
                beatQ <= 2'd0;
                asmQ  <= 32'h0;
            end
            if (state == SPLIT) begin
                asmQ  <= asmNext;
                beatQ <= beatQ + 2'd1;
                if (lastBeat) begin
                    resp_valid    <= 1'b1;
                    resp_data     <= splitData;
                    resp_exc      <= 2'b00;
                    resp_badvaddr <= 32'h0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: byte-array DM model plus a byte-level reference memory.
module tb_mem_access_master;
    localparam logic [31:0] DM_BASE   = 32'h0000_0000;
    localparam logic [31:0] DM_SIZE   = 32'h0000_3000;
    localparam int          MEM_BYTES = 32'h3000;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, req_pc = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data, resp_badvaddr;
    logic [1:0]  resp_exc;
    logic        MemWrite, MemRead, SignRead;
    logic [1:0]  StoreType, LoadType;
    logic [31:0] WPC, Addr, WD, RD;

    logic [7:0]  dmMem  [0:MEM_BYTES-1] = '{default: 8'h00};
    logic [7:0]  refMem [0:MEM_BYTES-1] = '{default: 8'h00};
    logic [31:0] dmWord;
    logic [31:0] rdHist [0:15];
    int          rdCnt = 0, wrCnt = 0;
    logic [1:0]  lastSt = 2'd0;
    logic [31:0] lastWpc = 32'h0;
    int          checks = 0, errors = 0;

    // scratch for observed / expected transaction results (initial block only)
    logic        got, rdy;
    int          lat, nRd, nWr, eLat, eRd, eWr;
    logic [31:0] data, bad, eData, eBad;
    logic [1:0]  exc, eExc;

    mem_access_master #(.DM_BASE(DM_BASE), .DM_SIZE(DM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_exc(resp_exc),
        .resp_badvaddr(resp_badvaddr),
        .MemWrite(MemWrite), .MemRead(MemRead), .StoreType(StoreType), .LoadType(LoadType),
        .SignRead(SignRead), .WPC(WPC), .Addr(Addr), .WD(WD), .RD(RD)
    );

    always #5 clk = ~clk;

    always_comb begin
        dmWord = 32'h0;
        for (int k = 0; k < 4; k++)
            if (Addr + 32'(k) < DM_SIZE) dmWord[8*k +: 8] = dmMem[14'(Addr + 32'(k))];
    end

    always_comb begin
        case (LoadType)
            2'd0:    RD = dmWord;
            2'd1:    RD = SignRead ? {{16{dmWord[15]}}, dmWord[15:0]} : {16'h0, dmWord[15:0]};
            default: RD = SignRead ? {{24{dmWord[7]}}, dmWord[7:0]} : {24'h0, dmWord[7:0]};
        endcase
    end

    always @(posedge clk) begin
        if (MemWrite) begin
            for (int k = 0; k < 4; k++)
                if (k < ((StoreType == 2'd0) ? 4 : (StoreType == 2'd1) ? 2 : 1) &&
                    (Addr + 32'(k) < DM_SIZE))
                    dmMem[14'(Addr + 32'(k))] <= WD[8*k +: 8];
        end
    end

    always @(negedge clk) begin
        if (MemRead) begin
            rdHist[rdCnt % 16] <= Addr;
            rdCnt <= rdCnt + 1;
        end
        if (MemWrite) begin
            wrCnt   <= wrCnt + 1;
            lastSt  <= StoreType;
            lastWpc <= WPC;
        end
    end

    // Reference: whole-access semantics on a byte array, independent of cycle structure.
    function automatic void refAccess(input logic [2:0] op, input logic [31:0] addr,
                                      input logic [31:0] wdata,
                                      output logic [31:0] d, output logic [1:0] x,
                                      output logic [31:0] b, output int l, output int r,
                                      output int w);
        int size, base;
        logic ld, inRange, aligned, err, split;
        longint unsigned a64;
        size    = (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
        ld      = (op < 3'd5);
        a64     = {32'h0, addr};
        inRange = (a64 >= {32'h0, DM_BASE}) &&
                  (a64 + 64'(size) <= {32'h0, DM_BASE} + {32'h0, DM_SIZE});
        aligned = (addr % 32'(size)) == 32'h0;
`ifdef MEM_SPLIT_MISALIGN_EN
        split = inRange && !aligned;
        err   = !inRange;
`else
        split = 1'b0;
        err   = !inRange || !aligned;
`endif
        d = 32'h0; x = 2'b00; b = 32'h0;
        l = split ? size + 1 : 1;
        r = (ld && !err) ? (split ? size : 1) : 0;
        w = (!ld && !err) ? (split ? size : 1) : 0;
        if (err) begin
            x = ld ? 2'b01 : 2'b10;
            b = addr;
        end else begin
            base = int'(addr - DM_BASE);
            for (int k = 0; k < size; k++) begin
                if (ld) d[8*k +: 8] = refMem[base + k];
                else    refMem[base + k] = wdata[8*k +: 8];
            end
            if (op == 3'd1) d = {{16{d[15]}}, d[15:0]};
            if (op == 3'd3) d = {{24{d[7]}}, d[7:0]};
        end
    endfunction

    task automatic doReq(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc);
        int rd0, wr0, n;
        @(negedge clk);
        req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd0 = rdCnt; wr0 = wrCnt;
        @(posedge clk); #1;
        rdy = req_ready;
        req_valid = 1'b0;
        got = 1'b0; lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) begin
                got = 1'b1; lat = i;
                break;
            end
        end
        data = resp_data; exc = resp_exc; bad = resp_badvaddr;
        nRd = rdCnt - rd0; nWr = wrCnt - wr0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_data, resp_exc, resp_badvaddr} !== {1'b1, 1'b0, 32'h0, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_resp: ready=%b valid=%b data=%h exc=%b bad=%h, required 1 0 0 0 0",
                     req_ready, resp_valid, resp_data, resp_exc, resp_badvaddr);
        end
        checks++;
        if ({MemWrite, MemRead, StoreType, LoadType, SignRead, WPC, Addr, WD} !== '0) begin
            errors++;
            $display("FAIL reset_dm: wr=%b rd=%b st=%0d lt=%0d sr=%b wpc=%h addr=%h wd=%h, required all 0",
                     MemWrite, MemRead, StoreType, LoadType, SignRead, WPC, Addr, WD);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, MemRead, MemWrite} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_idle: ready=%b valid=%b rd=%b wr=%b, required 1 0 0 0",
                     req_ready, resp_valid, MemRead, MemWrite);
        end
    endtask

    task automatic test_store_load();
        logic [2:0]  ops [0:8] = '{3'd5, 3'd0, 3'd6, 3'd0, 3'd1, 3'd2, 3'd7, 3'd3, 3'd4};
        logic [31:0] ads [0:8] = '{32'd0, 32'd0, 32'd2, 32'd0, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0};
        logic [31:0] wds [0:8] = '{32'h12345678, 32'h0, 32'h0000aabb, 32'h0, 32'h0, 32'h0,
                                   32'haabbccdd, 32'h0, 32'h0};
        logic [31:0] pc;
        for (int i = 0; i < 9; i++) begin
            pc = 32'h0040_0000 + 32'(i * 4);
            refAccess(ops[i], ads[i], wds[i], eData, eExc, eBad, eLat, eRd, eWr);
            doReq(ops[i], ads[i], wds[i], pc);
            checks++;
            if (got !== 1'b1 || rdy !== 1'b0 || lat != eLat || data !== eData || exc !== eExc ||
                bad !== eBad || nRd != eRd || nWr != eWr) begin
                errors++;
                $display("FAIL store_load[%0d] op=%0d addr=%h: got=%b busyReady=%b lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d; required 1 0 lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d",
                         i, ops[i], ads[i], got, rdy, lat, data, exc, bad, nRd, nWr, eLat, eData, eExc, eBad, eRd, eWr);
            end
            if (ops[i] >= 3'd5) begin
                checks++;
                if (lastSt !== ((ops[i] == 3'd5) ? 2'd0 : (ops[i] == 3'd6) ? 2'd1 : 2'd2) || lastWpc !== pc) begin
                    errors++;
                    $display("FAIL store_type[%0d]: StoreType=%0d WPC=%h, required op-derived type, WPC=%h",
                             i, lastSt, lastWpc, pc);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ops [0:9] = '{3'd0, 3'd6, 3'd0, 3'd0, 3'd3, 3'd7, 3'd0, 3'd1, 3'd0, 3'd5};
        logic [31:0] ads [0:9] = '{32'd1, 32'd3, 32'd0, DM_SIZE, DM_SIZE - 32'd1, DM_SIZE,
                                   32'hffff_fffc, 32'hffff_ffff, DM_SIZE - 32'd4, DM_SIZE - 32'd2};
        logic [31:0] wd;
        for (int i = 0; i < 10; i++) begin
            wd = $urandom();
            refAccess(ops[i], ads[i], wd, eData, eExc, eBad, eLat, eRd, eWr);
            doReq(ops[i], ads[i], wd, 32'h0040_1000);
            checks++;
            if (got !== 1'b1 || lat != eLat || data !== eData || exc !== eExc ||
                bad !== eBad || nRd != eRd || nWr != eWr) begin
                errors++;
                $display("FAIL errors[%0d] op=%0d addr=%h: got=%b lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d; required 1 lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d",
                         i, ops[i], ads[i], got, lat, data, exc, bad, nRd, nWr, eLat, eData, eExc, eBad, eRd, eWr);
            end
        end
    endtask

    task automatic test_split();
        logic [2:0]  ops [0:7] = '{3'd5, 3'd5, 3'd0, 3'd5, 3'd0, 3'd6, 3'd1, 3'd2};
        logic [31:0] ads [0:7] = '{32'd0, 32'd4, 32'd1, 32'd2, 32'd0, 32'd7, 32'd7, 32'd7};
        logic [31:0] wds [0:7] = '{32'haabb56dd, 32'h00000011, 32'h0, 32'hcafef00d, 32'h0,
                                   32'h00008001, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            refAccess(ops[i], ads[i], wds[i], eData, eExc, eBad, eLat, eRd, eWr);
            doReq(ops[i], ads[i], wds[i], 32'h0040_2000);
            checks++;
            if (got !== 1'b1 || lat != eLat || data !== eData || exc !== eExc ||
                bad !== eBad || nRd != eRd || nWr != eWr) begin
                errors++;
                $display("FAIL split[%0d] op=%0d addr=%h: got=%b lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d; required 1 lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d",
                         i, ops[i], ads[i], got, lat, data, exc, bad, nRd, nWr, eLat, eData, eExc, eBad, eRd, eWr);
            end
`ifdef MEM_SPLIT_MISALIGN_EN
            if (i == 2) begin
                checks++;
                if (rdHist[(rdCnt - 4) % 16] !== 32'd1 || rdHist[(rdCnt - 3) % 16] !== 32'd2 ||
                    rdHist[(rdCnt - 2) % 16] !== 32'd3 || rdHist[(rdCnt - 1) % 16] !== 32'd4) begin
                    errors++;
                    $display("FAIL split_beats: addrs %h %h %h %h, required 1 2 3 4",
                             rdHist[(rdCnt - 4) % 16], rdHist[(rdCnt - 3) % 16],
                             rdHist[(rdCnt - 2) % 16], rdHist[(rdCnt - 1) % 16]);
                end
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, wd;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            wd = $urandom();
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1, 2:    a = DM_SIZE - 32'd8 + 32'($urandom_range(0, 11));
                default: a = 32'($urandom_range(0, 63));
            endcase
            refAccess(op, a, wd, eData, eExc, eBad, eLat, eRd, eWr);
            doReq(op, a, wd, 32'($urandom()));
            checks++;
            if (got !== 1'b1 || lat != eLat || data !== eData || exc !== eExc ||
                bad !== eBad || nRd != eRd || nWr != eWr) begin
                errors++;
                $display("FAIL random[%0d] op=%0d addr=%h: got=%b lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d; required 1 lat=%0d data=%h exc=%b bad=%h rd=%0d wr=%0d",
                         i, op, a, got, lat, data, exc, bad, nRd, nWr, eLat, eData, eExc, eBad, eRd, eWr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        wd = $urandom();
        refAccess(3'd5, 32'd32, wd, eData, eExc, eBad, eLat, eRd, eWr);
        doReq(3'd5, 32'd32, wd, 32'h0040_3000);
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: resp_valid=%b req_ready=%b, required 1 1", resp_valid, req_ready);
        end
        refAccess(3'd0, 32'd32, 32'h0, eData, eExc, eBad, eLat, eRd, eWr);
        doReq(3'd0, 32'd32, 32'h0, 32'h0040_3004);
        checks++;
        if (got !== 1'b1 || lat != eLat || data !== eData || exc !== eExc) begin
            errors++;
            $display("FAIL b2b_load: got=%b lat=%0d data=%h exc=%b, required 1 %0d %h %b",
                     got, lat, data, exc, eLat, eData, eExc);
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== eData) begin
            errors++;
            $display("FAIL b2b_hold: resp_valid=%b data=%h, required 0 %h", resp_valid, resp_data, eData);
        end
    endtask

    task automatic test_reset_abort();
        logic sawResp;
        logic [31:0] wd;
        wd = $urandom() | 32'h0000_0001;
        @(negedge clk);
        req_op = 3'd5; req_addr = 32'h10; req_wdata = wd; req_pc = 32'h0040_4000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL abort_strobe: MemWrite=%b, required 1", MemWrite);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_async: MemWrite=%b req_ready=%b, required 0 1", MemWrite, req_ready);
        end
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        sawResp = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) sawResp = 1'b1;
        end
        checks++;
        if (sawResp !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_noresp: sawResp=%b req_ready=%b, required 0 1", sawResp, req_ready);
        end
        refAccess(3'd0, 32'h10, 32'h0, eData, eExc, eBad, eLat, eRd, eWr);
        doReq(3'd0, 32'h10, 32'h0, 32'h0040_4004);
        checks++;
        if (got !== 1'b1 || data !== eData || exc !== eExc) begin
            errors++;
            $display("FAIL abort_mem: got=%b data=%h exc=%b, required 1 %h %b", got, data, exc, eData, eExc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_split();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
